serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Bit-serial frame receiver that sits directly downstream of the single-bit two-flop delay stage (`d` → `q_next` → `q`) and consumes its `q` output as a serial line. It samples one bit per clock and recognises start/data/parity/stop frames. It reassembles each frame LSB-first into a parallel word, then reports the word with a one-cycle valid pulse plus parity and framing error flags.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 1–16.
- `PARITY_EN`, default 1: 1 inserts one parity bit between data and stop; 0 omits it.
- `PARITY_ODD`, default 0: with `PARITY_EN=1`, 0 selects even parity and 1 selects odd.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ser_in` input 1: serial line, driven from the upstream stage's `q`; it idles high.
- `data_out` output `DATA_W`: last received word; held until the next frame completes.
- `data_valid` output 1: one-cycle pulse when `data_out`, `parity_err` and `frame_err` are updated.
- `parity_err` output 1: parity mismatch for the frame reported with the current `data_valid`.
- `frame_err` output 1: stop bit was 0 for the frame reported with the current `data_valid`.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Reset value:** state = IDLE, `data_out = 0`, and `data_valid`, `parity_err`, `frame_err`, `busy` are all 0.
- **Reset mid-frame:** the frame is abandoned, no `data_valid` is produced, and the block returns to IDLE next cycle.
- **States and transitions:**
  - IDLE: if `ser_in == 0` (start bit), go to DATA with bit counter = 0; otherwise stay.
  - DATA: shift `ser_in` into the shift register at bit position `cnt` (LSB first) and increment `cnt`. After the `DATA_W`-th bit, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: capture the parity bit. The expected bit is the XOR of the data bits, inverted when `PARITY_ODD=1`.
  - STOP: sample the stop bit. Register `data_out` ← shift register, `data_valid` ← 1, `parity_err` ← mismatch (forced to 0 if `!PARITY_EN`), and `frame_err` ← `!ser_in`.
    - `ser_in == 1`: go to IDLE.
    - `ser_in == 0`: go to WAIT_IDLE.
  - WAIT_IDLE: stay until `ser_in == 1`, then go to IDLE. A low `ser_in` here is never taken as a start bit.
- **Error flags:** `parity_err` and `frame_err` are valid only in the `data_valid` cycle. They are 0 in all other cycles.
- **Frames with errors:** `data_valid` still pulses and `data_out` still updates; the error flags qualify the word.
- **Bit counter:** sized `$clog2(DATA_W+1)` and cleared on entry to DATA. It never wraps inside a frame.

## Timing
- Let edge E0 be the edge that samples the start bit. Data bits are sampled at E1..E`DATA_W`.
- The parity bit is sampled at E`DATA_W+1` (if enabled). The stop bit is sampled at the next edge, Es.
- `data_valid` is high for exactly one cycle, starting after edge Es.
  - Defaults (8 data bits, parity on): Es = E10, so the pulse follows E10.
  - `PARITY_EN=0`: Es = E9.
- **Back-to-back frames:** a start bit sampled at Es+1 is accepted. Frames are therefore `DATA_W+2+PARITY_EN` cycles apart, with no dead cycle.
- `busy` rises after E0 and falls after the edge that enters IDLE.

## Structure
- Package `serial_frame_pkg` holds:
  - the state typedef `rx_state_t` (IDLE, DATA, PARITY, STOP, WAIT_IDLE);
  - the function `calc_parity(data, odd)`.
- Single module; no sub-module is needed.
- The parity checker is combinational, driven from the shift register via the package function.
- All outputs are registered.

## Test plan
- **Good frame:** `ser_in` = 0, then 1,0,1,0,0,1,0,1 (8'hA5), then parity 0, then stop 1. Expect `data_out = 8'hA5`, a single-cycle `data_valid` after E10, `parity_err = 0`, `frame_err = 0`.
- **Parity error:** same frame with parity bit 1. Expect `data_out = 8'hA5`, `data_valid = 1`, `parity_err = 1`, `frame_err = 0`.
- **Framing error:** 8'h3C, correct parity, stop = 0, then `ser_in` held 0 for 5 cycles, then 1. Expect `frame_err = 1` in the valid cycle and `busy = 1` until the cycle after `ser_in` returns high. No second `data_valid` appears.
- **Back-to-back:** 8'h3C then 8'hFF, with the second start bit immediately after the first stop bit. Expect two `data_valid` pulses exactly 11 cycles apart, carrying 8'h3C then 8'hFF with no errors.
- **Reset mid-frame:** assert `rst` for 1 cycle after 4 data bits of 8'hA5. Expect no `data_valid` and all outputs 0. The next full frame 8'h5A is received correctly.
- **Parity off:** instance with `PARITY_EN=0` receives 8'h01 (start, 1,0,0,0,0,0,0,0, stop 1). Expect `data_valid` after E9, `data_out = 8'h01`, `parity_err = 0`.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and helpers for the bit-serial frame receiver.
package serial_frame_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Zero-padding to MAX_W leaves the XOR unchanged, so any DATA_W fits.
    function automatic logic calc_parity(input logic [MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line and parallel result bundle for serial_frame_rx.
interface serial_frame_rx_if #(parameter int DATA_W = 8) ();

    logic              ser_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        input  ser_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        output ser_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

endinterface

// File: rtl/serial_frame_rx.sv
// Bit-serial start/data/parity/stop receiver; one bit per clock, LSB first.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a low start bit
// DATA      | shifting DATA_W data bits into the shift register
// PARITY    | capturing the parity bit (only when PARITY_EN)
// STOP      | sampling stop bit, publishing word and error flags
// WAIT_IDLE | stop bit was low; wait for line high before rearming
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    serial_frame_rx_if.master  rx
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_exp;
    logic              par_mis;
    logic              last_bit;
    logic [MAX_W-1:0]  shreg_ext;

    assign shreg_ext = MAX_W'(shreg);
    assign par_exp   = calc_parity(shreg_ext, 1'(PARITY_ODD));
    assign par_mis   = (PARITY_EN != 0) && (par_bit != par_exp);
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx.ser_in) state_nxt = DATA;
            DATA:      if (last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    state_nxt = STOP;
            STOP:      state_nxt = rx.ser_in ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx.ser_in) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            state         <= state_nxt;
            rx.busy       <= (state_nxt != IDLE);
            rx.data_valid <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                DATA: begin
                    shreg[cnt[IDX_W-1:0]] <= rx.ser_in;
                    cnt                   <= cnt + CNT_W'(1);
                end
                PARITY: par_bit <= rx.ser_in;
                STOP: begin
                    rx.data_out   <= shreg;
                    rx.data_valid <= 1'b1;
                    rx.parity_err <= par_mis;
                    rx.frame_err  <= !rx.ser_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: parity-on instance (a) and parity-off instance (b).
module tb_serial_frame_rx;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_rx_if #(.DATA_W(8)) bus_a ();
    serial_frame_rx_if #(.DATA_W(8)) bus_b ();

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .rx  (bus_a)
    );

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .rx  (bus_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   valid_cyc_a[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus_a.data_valid) begin
                valid_cyc_a.push_back(cyc);
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", bus_a.data_out, e.data);
                    check("a_parity_err", bus_a.parity_err, e.perr);
                    check("a_frame_err", bus_a.frame_err, e.ferr);
                    check("a_valid_cycle", cyc, e.cyc);
                end
            end else begin
                check("a_perr_outside_valid", bus_a.parity_err, 0);
                check("a_ferr_outside_valid", bus_a.frame_err, 0);
            end
            if (bus_b.data_valid) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", bus_b.data_out, e.data);
                    check("b_parity_err", bus_b.parity_err, e.perr);
                    check("b_frame_err", bus_b.frame_err, e.ferr);
                    check("b_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit inst, input logic b);
        @(posedge clk);
        #1;
        if (inst) bus_b.ser_in = b;
        else      bus_a.ser_in = b;
    endtask

    // Even parity on instance a; par_bad sends the wrong parity bit.
    task automatic send_frame(input bit inst, input logic [7:0] d, input bit par_en,
                              input bit par_bad, input logic stop);
        exp_t e;
        drive(inst, 1'b0);
        e.cyc  = cyc + 1 + 8 + int'(par_en) + 1;
        e.data = d;
        e.perr = par_en & par_bad;
        e.ferr = !stop;
        if (inst) q_b.push_back(e);
        else      q_a.push_back(e);
        for (int i = 0; i < 8; i++) drive(inst, d[i]);
        if (par_en) drive(inst, (^d) ^ par_bad);
        drive(inst, stop);
    endtask

    task automatic idle(input bit inst, input int n);
        for (int i = 0; i < n; i++) drive(inst, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] a5;
        rst          = 1'b1;
        bus_a.ser_in = 1'b1;
        bus_b.ser_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", bus_a.data_out, 0);
        check("rst_valid", bus_a.data_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_perr", bus_a.parity_err, 0);
        check("rst_ferr", bus_a.frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, 2);

        // good frame, then hold check
        send_frame(0, 8'hA5, 1, 0, 1);
        idle(0, 4);
        check("hold_data_out", bus_a.data_out, 8'hA5);
        check("idle_busy", bus_a.busy, 0);

        // parity error
        send_frame(0, 8'hA5, 1, 1, 1);
        idle(0, 3);

        // framing error with stretched low line
        send_frame(0, 8'h3C, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0);
            @(negedge clk);
            check("ferr_busy_low_line", bus_a.busy, 1);
        end
        drive(0, 1'b1);
        @(negedge clk);
        check("ferr_busy_before_high", bus_a.busy, 1);
        @(negedge clk);
        check("ferr_busy_after_high", bus_a.busy, 0);
        idle(0, 3);

        // back-to-back frames
        valid_cyc_a.delete();
        send_frame(0, 8'h3C, 1, 0, 1);
        send_frame(0, 8'hFF, 1, 0, 1);
        idle(0, 4);
        check("b2b_pulse_count", valid_cyc_a.size(), 2);
        if (valid_cyc_a.size() == 2)
            check("b2b_spacing", valid_cyc_a[1] - valid_cyc_a[0], 11);

        // reset mid-frame after four data bits
        a5 = 8'hA5;
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, a5[i]);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus_a.ser_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data_out", bus_a.data_out, 0);
        check("midrst_valid", bus_a.data_valid, 0);
        check("midrst_busy", bus_a.busy, 0);
        check("midrst_perr", bus_a.parity_err, 0);
        check("midrst_ferr", bus_a.frame_err, 0);
        idle(0, 12);
        check("midrst_still_idle", bus_a.busy, 0);
        send_frame(0, 8'h5A, 1, 0, 1);
        idle(0, 4);

        // parity disabled instance
        send_frame(1, 8'h01, 0, 0, 1);
        idle(1, 4);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("a_missing_valid", q_a.size(), 0);
        check("b_missing_valid", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
